fp_div_seq: RTL and testbench
=============================

FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 7, stored mantissa width; W = 1+EXP_W+MAN_W (default 16, bfloat16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand pair a, b offered.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 a  input  W  dividend, IEEE-style {sign, exp, man}, bias 2^(EXP_W-1)-1.
REQ-008 b  input  W  divisor, same format.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  W  quotient a/b.
REQ-012 flags  output  4  {nv, dz, of, uf}: invalid, divide-by-zero, overflow, underflow.

Function
REQ-013 FSM states IDLE, DIVIDE, NORM, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 IDLE->DIVIDE on in_valid&in_ready; a and b SHALL be captured at that edge and ignored thereafter.
REQ-015 DIVIDE SHALL run exactly MAN_W+3 cycles, one restoring radix-2 quotient bit per cycle, on significands 1.man_a / 1.man_b.
REQ-016 NORM SHALL last 1 cycle: normalise, round, and apply exponent/special-case selection; then DONE.
REQ-017 Latency SHALL be fixed for all operands, including special cases: out_valid rises MAN_W+5 cycles after the accept edge (12 at defaults).
REQ-018 In DONE, out_valid=1; result and flags SHALL hold stable until out_valid&out_ready, then DONE->IDLE; in_ready stays 0 in the handoff cycle.
REQ-019 Sign = sign_a XOR sign_b for all non-NaN results.
REQ-020 Exponent arithmetic SHALL use signed EXP_W+2 bits: e = ea - eb + bias, minus 1 when the quotient integer bit is 0.
REQ-021 Rounding SHALL be round-to-nearest-even using guard bit plus sticky (dropped quotient bits OR nonzero remainder); a mantissa carry-out SHALL increment e.
REQ-022 Exponent field 0 SHALL be treated as zero (subnormals flushed on input); results never subnormal.
REQ-023 Final e >= 2^EXP_W-1 -> signed infinity, of=1; final e <= 0 -> signed zero, uf=1.
REQ-024 NaN operand, 0/0, or inf/inf -> canonical NaN (sign 0, exp all ones, man MSB only; 0x7FC0 at defaults), nv=1.
REQ-025 Finite nonzero / 0 -> signed infinity, dz=1; 0/finite and finite/inf -> signed zero; inf/finite -> signed infinity; flags otherwise 0.
REQ-026 Outside DONE, result and flags SHALL read 0.

Reset
REQ-027 rst_n low SHALL force IDLE, in_ready=1 (after release), out_valid=0, result=0, flags=0, datapath registers cleared, immediately and regardless of clk.
REQ-028 Reset mid-DIVIDE, NORM or DONE SHALL abort the operation; no result for it is ever presented.

Structure
REQ-029 Package fp_pkg SHALL hold the FSM state enum, flag bit indices, and the bias/canonical-NaN constant functions of EXP_W and MAN_W.
REQ-030 Sub-module fp_div_mant_iter SHALL implement the iterative restoring significand divider (load, step, quotient, remainder-nonzero); FSM, exponent, rounding and specials stay in fp_div_seq.

Verification
REQ-031 a=0x40C0 (6.0), b=0x4040 (3.0) -> result 0x4000, flags 0, out_valid exactly 12 cycles after accept.
REQ-032 a=0x40A0, b=0x4000 -> 0x4020; a=0x3F80, b=0x4040 (1/3) -> 0x3EAB (RNE round-up), flags 0.
REQ-033 a=0x3F80, b=0x0000 -> 0x7F80, dz=1; a=0x0000, b=0x0000 -> 0x7FC0, nv=1; a=0xC000, b=0x7F80 -> 0x8000, flags 0.
REQ-034 a=0x7F7F, b=0x3F00 -> 0x7F80, of=1; a=0x0080, b=0x4000 -> 0x0000, uf=1.
REQ-035 out_ready held low 5 cycles in DONE -> result/flags unchanged, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-036 rst_n pulsed low mid-DIVIDE -> out_valid=0 immediately, no stale result; next op 4.0/2.0 -> 0x4000 with normal latency.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point divider.
//   state_t        : divider control FSM states
//   FLAG_*         : bit positions inside the 4-bit {nv, dz, of, uf} flag vector
//   fp_bias()      : exponent bias for a given exponent width
//   fp_canon_nan() : canonical quiet NaN (sign 0, exp all ones, mantissa MSB only)
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int FLAG_NV = 3;
    localparam int FLAG_DZ = 2;
    localparam int FLAG_OF = 1;
    localparam int FLAG_UF = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Returned in a wide vector; callers truncate to their word width.
    function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w);
        logic [63:0] ones;
        ones = (64'd1 << exp_w) - 64'd1;
        return (ones << man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_div_mant_iter.sv
// Iterative restoring radix-2 significand divider.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture dividend/divisor significands (1.man form), clear quotient
//   step       : produce one quotient bit (MSB first)
//   dividend   : 1.man_a, MAN_W+1 bits
//   divisor    : 1.man_b, MAN_W+1 bits
//   quot       : accumulated quotient bits, first bit produced is the integer bit
//   rem_nz     : partial remainder is nonzero (feeds the rounding sticky bit)
module fp_div_mant_iter
    import fp_pkg::*;
#(
    parameter int MAN_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [MAN_W:0]   dividend,
    input  logic [MAN_W:0]   divisor,
    output logic [MAN_W+2:0] quot,
    output logic             rem_nz
);

    // The partial remainder stays below twice the divisor, so one bit of
    // headroom above the significand width is sufficient.
    localparam int RW = MAN_W + 2;

    logic [RW-1:0]    rem_reg;
    logic [RW-1:0]    dvs_reg;
    logic [MAN_W+2:0] quot_reg;
    logic             ge;
    logic [RW-1:0]    rem_sel;

    assign ge      = (rem_reg >= dvs_reg);
    assign rem_sel = ge ? (rem_reg - dvs_reg) : rem_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_reg  <= '0;
            dvs_reg  <= '0;
            quot_reg <= '0;
        end else if (load) begin
            rem_reg  <= {1'b0, dividend};
            dvs_reg  <= {1'b0, divisor};
            quot_reg <= '0;
        end else if (step) begin
            quot_reg <= {quot_reg[MAN_W+1:0], ge};
            // rem_sel < divisor here, so its top bit is always zero.
            rem_reg  <= {rem_sel[RW-2:0], 1'b0};
        end
    end

    assign quot   = quot_reg;
    assign rem_nz = |rem_reg;

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-style floating-point divider (bfloat16 at default parameters).
// Fixed latency for every operand pair, including special cases.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake; in_ready only while IDLE
//   a, b                : dividend and divisor {sign, exp, man}
//   out_valid/out_ready : result handshake; result held in DONE until accepted
//   result              : quotient a/b (0 outside DONE)
//   flags               : {nv, dz, of, uf} (0 outside DONE)
module fp_div_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int EW    = EXP_W + 2;
    localparam int STEPS = MAN_W + 3;
    localparam int CW    = $clog2(STEPS);

    localparam logic [W-1:0]         NAN_VAL = W'(fp_canon_nan(EXP_W, MAN_W));
    localparam logic signed [EW-1:0] BIAS_E  = EW'(fp_bias(EXP_W));
    localparam logic signed [EW-1:0] E_MAX   = EW'((1 << EXP_W) - 1);

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg;
    logic [W-1:0]      a_reg, b_reg;
    logic [W-1:0]      res_reg, res_next;
    logic [3:0]        flags_reg, flags_next;
    logic              accept;
    logic              last_step;

    logic [MAN_W+2:0]  quot;
    logic              rem_nz;

    assign accept    = in_valid && (state_reg == IDLE);
    assign last_step = (cnt_reg == CW'(STEPS - 1));

    // Significand divider is loaded straight from the ports on the accept
    // edge so the first quotient bit is produced in the first DIVIDE cycle.
    fp_div_mant_iter #(
        .MAN_W (MAN_W)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .step     (state_reg == DIVIDE),
        .dividend ({1'b1, a[MAN_W-1:0]}),
        .divisor  ({1'b1, b[MAN_W-1:0]}),
        .quot     (quot),
        .rem_nz   (rem_nz)
    );

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            flags_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg   <= a;
                b_reg   <= b;
                cnt_reg <= '0;
            end else if (state_reg == DIVIDE) begin
                cnt_reg <= cnt_reg + CW'(1);
            end
            if (state_reg == NORM) begin
                res_reg   <= res_next;
                flags_reg <= flags_next;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = DIVIDE;
            end
            DIVIDE: if (last_step) state_next = NORM;
            NORM:   state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign result = (state_reg == DONE) ? res_reg : '0;
    assign flags  = (state_reg == DONE) ? flags_reg : '0;

    // ---------------- normalise / round / specials ----------------
    logic [EXP_W-1:0]  ea, eb;
    logic [MAN_W-1:0]  ma, mb;
    logic              sign_q;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [MAN_W-1:0]  mant;
    logic              guard, sticky, round_up;
    logic [MAN_W:0]    mant_rnd;
    logic signed [EW-1:0] e_base, e_fin;
    logic [W-1:0]      inf_val, zero_val;

    assign {ea, ma} = a_reg[W-2:0];
    assign {eb, mb} = b_reg[W-2:0];
    assign sign_q   = a_reg[W-1] ^ b_reg[W-1];

    // Exponent field 0 is zero regardless of mantissa (subnormals flushed).
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (ma == '0);
    assign b_inf  = (&eb) && (mb == '0);
    assign a_nan  = (&ea) && (ma != '0);
    assign b_nan  = (&eb) && (mb != '0);

    assign inf_val  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign zero_val = {sign_q, {(W-1){1'b0}}};

    // Quotient lies in (0.5, 2): when the integer bit is 0 the leading one
    // is the next bit and the kept field shifts down by one.
    always_comb begin
        if (quot[MAN_W+2]) begin
            mant   = quot[MAN_W+1:2];
            guard  = quot[1];
            sticky = quot[0] | rem_nz;
        end else begin
            mant   = quot[MAN_W:1];
            guard  = quot[0];
            sticky = rem_nz;
        end
    end

    assign round_up = guard & (sticky | mant[0]);
    assign mant_rnd = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};

    assign e_base = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_E
                    - $signed({{(EW-1){1'b0}}, ~quot[MAN_W+2]});
    // A rounding carry out of the mantissa leaves the field at zero and
    // bumps the exponent.
    assign e_fin  = e_base + $signed({{(EW-1){1'b0}}, mant_rnd[MAN_W]});

    always_comb begin
        res_next   = {sign_q, e_fin[EXP_W-1:0], mant_rnd[MAN_W-1:0]};
        flags_next = '0;
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            res_next            = NAN_VAL;
            flags_next[FLAG_NV] = 1'b1;
        end else if (a_inf) begin
            res_next = inf_val;
        end else if (b_inf) begin
            res_next = zero_val;
        end else if (b_zero) begin
            res_next            = inf_val;
            flags_next[FLAG_DZ] = 1'b1;
        end else if (a_zero) begin
            res_next = zero_val;
        end else if (e_fin >= E_MAX) begin
            res_next            = inf_val;
            flags_next[FLAG_OF] = 1'b1;
        end else if (e_fin[EW-1] || (e_fin == '0)) begin
            res_next            = zero_val;
            flags_next[FLAG_UF] = 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed, table-driven bench for fp_div_seq at bfloat16 defaults.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic [3:0]  flags;

    int n_vec = 0;
    int n_bad = 0;

    localparam int LAT = 12;

    always #5 clk = ~clk;

    fp_div_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flg;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Offer one operand pair, accept on the next rising edge, then drive
    // junk on a/b to make sure the captured operands are the ones used.
    task automatic start_op(input logic [15:0] xa, input logic [15:0] xb);
        int g;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = xa;
        b = xb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'h7FC1;
        b = 16'h0000;
    endtask

    // Counts cycles from the accept edge until out_valid is seen.
    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 5) begin
                chk({tag, ".busy_result"}, 32'(result), 32'd0);
                chk({tag, ".busy_flags"}, 32'(flags), 32'd0);
                chk({tag, ".busy_in_ready"}, 32'(in_ready), 32'd0);
            end
        end while (!out_valid && lat < 40);
        if (!out_valid) chk({tag, ".timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic finish_op(input string tag);
        chk({tag, ".handoff_in_ready"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".released_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".released_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int seen;
        string tag;

        vecs[0]  = '{16'h40C0, 16'h4040, 16'h4000, 4'b0000}; //  6 / 3
        vecs[1]  = '{16'h40A0, 16'h4000, 16'h4020, 4'b0000}; //  5 / 2
        vecs[2]  = '{16'h3F80, 16'h4040, 16'h3EAB, 4'b0000}; //  1 / 3, rounds up
        vecs[3]  = '{16'h3F80, 16'h0000, 16'h7F80, 4'b0100}; //  1 / 0
        vecs[4]  = '{16'h0000, 16'h0000, 16'h7FC0, 4'b1000}; //  0 / 0
        vecs[5]  = '{16'hC000, 16'h7F80, 16'h8000, 4'b0000}; // -2 / inf
        vecs[6]  = '{16'h7F7F, 16'h3F00, 16'h7F80, 4'b0010}; // max / 0.5
        vecs[7]  = '{16'h0080, 16'h4000, 16'h0000, 4'b0001}; // min normal / 2
        vecs[8]  = '{16'hC0C0, 16'h4040, 16'hC000, 4'b0000}; // -6 / 3
        vecs[9]  = '{16'h7F80, 16'h7F80, 16'h7FC0, 4'b1000}; // inf / inf
        vecs[10] = '{16'h7FC1, 16'h3F80, 16'h7FC0, 4'b1000}; // NaN / 1
        vecs[11] = '{16'hFF80, 16'h4000, 16'hFF80, 4'b0000}; // -inf / 2
        vecs[12] = '{16'h0000, 16'h40A0, 16'h0000, 4'b0000}; //  0 / 5
        vecs[13] = '{16'hBF80, 16'h8000, 16'h7F80, 4'b0100}; // -1 / -0
        vecs[14] = '{16'h4000, 16'h4000, 16'h3F80, 4'b0000}; //  2 / 2
        vecs[15] = '{16'h3F80, 16'h3F81, 16'h3F7E, 4'b0000}; //  1 / 1.0078125, rounds down
        vecs[16] = '{16'h0001, 16'h3F80, 16'h0000, 4'b0000}; //  subnormal flushed / 1

        // Reset state, sampled while reset is held.
        #12;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.result", 32'(result), 32'd0);
        chk("reset.flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset.in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 17; i++) begin
            tag = $sformatf("v%0d", i);
            start_op(vecs[i].a, vecs[i].b);
            wait_valid(tag, lat);
            chk({tag, ".latency"}, 32'(lat), 32'(LAT));
            chk({tag, ".result"}, 32'(result), 32'(vecs[i].res));
            chk({tag, ".flags"}, 32'(flags), 32'(vecs[i].flg));
            finish_op(tag);
        end

        // Consumer stall: held result, no new accept while DONE.
        start_op(16'h40C0, 16'h4040);
        wait_valid("stall", lat);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            a = 16'h3F80;
            b = 16'h4040;
            @(negedge clk);
            chk($sformatf("stall%0d.result", k), 32'(result), 32'h4000);
            chk($sformatf("stall%0d.flags", k), 32'(flags), 32'd0);
            chk($sformatf("stall%0d.in_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("stall%0d.out_valid", k), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        finish_op("stall");

        // Asynchronous reset in the middle of DIVIDE aborts the operation.
        start_op(16'h40C0, 16'h4040);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort.out_valid", 32'(out_valid), 32'd0);
        chk("abort.result", 32'(result), 32'd0);
        chk("abort.flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort.in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort.stale_out_valid", 32'(seen), 32'd0);

        start_op(16'h4080, 16'h4000);
        wait_valid("after_abort", lat);
        chk("after_abort.latency", 32'(lat), 32'(LAT));
        chk("after_abort.result", 32'(result), 32'h4000);
        chk("after_abort.flags", 32'(flags), 32'd0);
        finish_op("after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
